// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Brief    : Shared types and constants for the program loader.
// Revision : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int unsigned c_default_addr_w    = 10;
    localparam int unsigned c_default_max_words = 1024;
    localparam logic [31:0] c_hlt_opcode        = 32'hfc000000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Streams a program into instruction memory, releases the core,
//            waits for HLT. Optional PROG_LOADER_CHECKSUM_EN adds a word sum.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = c_default_addr_w,
    parameter int MAX_WORDS = c_default_max_words
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_pc_clr,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
`ifdef PROG_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(MAX_WORDS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR_W:0] r_word_count;
    logic            r_err_overflow;
    logic            r_run_first;
    logic            w_accept;
    logic            w_at_cap;
    logic            w_start_load;

    assign w_at_cap     = (r_word_count == c_last_idx);
    assign w_start_load = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        core_hold   = 1'b1;
        core_pc_clr = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_accept  = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = r_word_count[ADDR_W-1:0];
                    mem_wdata = in_data;
                    if (in_last)       w_state_nxt = RELEASE;
                    else if (w_at_cap) w_state_nxt = DONE;
                end
            end
            RELEASE: begin
                core_pc_clr = 1'b1;
                busy        = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                core_hold = 1'b0;
                busy      = 1'b1;
                // The core's halt flag may still be stale from the previous program
                // during the first RUN cycle, so it is only trusted afterwards.
                if (!r_run_first && core_halted) w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = LOAD;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state        <= IDLE;
            r_word_count   <= '0;
            r_err_overflow <= 1'b0;
            r_run_first    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_first <= (r_state == RELEASE);
            if (w_start_load) begin
                r_word_count   <= '0;
                r_err_overflow <= 1'b0;
            end else if (w_accept) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_accept && !in_last && w_at_cap) r_err_overflow <= 1'b1;
        end
    end

    assign word_count   = r_word_count;
    assign err_overflow = r_err_overflow;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_load) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Directed + randomized self-checking bench for prog_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        core_halted;

    logic        a_in_ready, a_mem_we, a_core_hold, a_core_pc_clr, a_busy, a_done, a_err;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [10:0] a_word_count;
    logic        b_in_ready, b_mem_we, b_core_hold, b_core_pc_clr, b_busy, b_done, b_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] a_checksum, b_checksum;
`endif

    always #5 clk1 = ~clk1;

    prog_loader dut_a (
        .clk1(clk1), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .core_hold(a_core_hold), .core_pc_clr(a_core_pc_clr), .core_halted(core_halted),
        .busy(a_busy), .done(a_done), .word_count(a_word_count),
`ifdef PROG_LOADER_CHECKSUM_EN
        .checksum(a_checksum),
`endif
        .err_overflow(a_err)
    );

    prog_loader #(.ADDR_W(2), .MAX_WORDS(4)) dut_b (
        .clk1(clk1), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .core_hold(b_core_hold), .core_pc_clr(b_core_pc_clr), .core_halted(core_halted),
        .busy(b_busy), .done(b_done), .word_count(b_word_count),
`ifdef PROG_LOADER_CHECKSUM_EN
        .checksum(b_checksum),
`endif
        .err_overflow(b_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t obs_q[$];
    int  a_pcclr_cnt = 0;
    int  b_pcclr_cnt = 0;
    int  b_we_cnt    = 0;

    // Passive observer of memory-side traffic; the stimulus block only reads these.
    always @(negedge clk1) begin
        if (a_mem_we) obs_q.push_back({32'(a_mem_addr), a_mem_wdata});
        if (a_core_pc_clr) a_pcclr_cnt++;
        if (b_core_pc_clr) b_pcclr_cnt++;
        if (b_mem_we) b_we_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // gap_mode: 0 = no gaps, 1 = one idle cycle before every word after the first,
    // 2 = random 0..2 idle cycles. halt_delay 0 raises core_halted (and start) in the
    // first RUN cycle, which must be ignored.
    task automatic run_prog(input logic [31:0] prog[$], input int gap_mode, input int halt_delay);
        int          base_w;
        int          base_p;
        int          n;
        int          ng;
        logic [31:0] sum;
        n      = prog.size();
        base_w = obs_q.size();
        base_p = a_pcclr_cnt;
        sum    = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("load_ready", 64'(a_in_ready), 64'd1);
        chk("load_wc0", 64'(a_word_count), 64'd0);
        chk("load_busy", 64'(a_busy), 64'd1);

        for (int i = 0; i < n; i++) begin
            ng = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
                 (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                #1;
                chk("gap_we", 64'(a_mem_we), 64'd0);
                chk("gap_wc", 64'(a_word_count), 64'(i));
                tick();
            end
            in_valid = 1'b1;
            in_data  = prog[i];
            in_last  = (i == n - 1);
            #1;
            chk("acc_we", 64'(a_mem_we), 64'd1);
            chk("acc_addr", 64'(a_mem_addr), 64'(i));
            chk("acc_data", 64'(a_mem_wdata), 64'(prog[i]));
            sum = sum + prog[i];
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end

        #1;
        chk("rel_pcclr", 64'(a_core_pc_clr), 64'd1);
        chk("rel_hold", 64'(a_core_hold), 64'd1);
        chk("rel_wc", 64'(a_word_count), 64'(n));
        tick();
        chk("run_hold", 64'(a_core_hold), 64'd0);
        chk("run_pcclr", 64'(a_core_pc_clr), 64'd0);

        if (halt_delay == 0) begin
            core_halted = 1'b1;
            start       = 1'b1;
            tick();
            start = 1'b0;
            #1;
            chk("run1_halt_ignored", 64'(a_core_hold), 64'd0);
            chk("run_start_ignored", 64'({a_busy, a_in_ready}), 64'b10);
        end else begin
            repeat (halt_delay) begin
                tick();
                chk("run_hold_wait", 64'(a_core_hold), 64'd0);
            end
            core_halted = 1'b1;
        end
        tick();
        core_halted = 1'b0;
        #1;
        chk("done", 64'(a_done), 64'd1);
        chk("done_hold", 64'(a_core_hold), 64'd1);
        chk("done_busy", 64'(a_busy), 64'd0);
        chk("done_err", 64'(a_err), 64'd0);

        chk("n_writes", 64'(obs_q.size() - base_w), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 64'(obs_q[base_w + i].addr), 64'(i));
            chk("wr_data", 64'(obs_q[base_w + i].data), 64'(prog[i]));
        end
        chk("pcclr_pulses", 64'(a_pcclr_cnt - base_p), 64'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
        tick();
        chk("checksum", 64'(a_checksum), 64'(sum));
`endif
    endtask

    logic [31:0] prog[$];
    int          b_base_p;
    int          b_base_w;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'hdeadbeef;
        in_last     = 1'b0;
        core_halted = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_ready", 64'(a_in_ready), 64'd0);
        chk("rst_hold", 64'(a_core_hold), 64'd1);
        chk("rst_we", 64'(a_mem_we), 64'd0);
        chk("rst_addr_data", 64'({a_mem_addr, a_mem_wdata}), 64'd0);
        chk("rst_status", 64'({a_busy, a_done, a_err, a_core_pc_clr}), 64'd0);
        chk("rst_wc", 64'(a_word_count), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, c_hlt_opcode};
        run_prog(prog, 0, 3);
        run_prog(prog, 1, 0);

        // Overflow on the four-word instance; the wide instance just keeps loading.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        b_base_p = b_pcclr_cnt;
        b_base_w = b_we_cnt;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b0;
            #1;
            if (i < 4) begin
                chk("ovf_we", 64'(b_mem_we), 64'd1);
                chk("ovf_addr", 64'(b_mem_addr), 64'(i));
            end else begin
                chk("ovf_5th_we", 64'(b_mem_we), 64'd0);
                chk("ovf_5th_ready", 64'(b_in_ready), 64'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("ovf_err", 64'(b_err), 64'd1);
        chk("ovf_done", 64'(b_done), 64'd1);
        chk("ovf_hold", 64'({b_core_hold, b_busy}), 64'b10);
        chk("ovf_wc", 64'(b_word_count), 64'd4);
        chk("ovf_writes", 64'(b_we_cnt - b_base_w), 64'd4);
        chk("ovf_no_pcclr", 64'(b_pcclr_cnt - b_base_p), 64'd0);
        chk("ovf_wide_no_err", 64'(a_err), 64'd0);

        // Reset in the middle of a load.
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wc", 64'(a_word_count), 64'd0);
        chk("midrst_ready", 64'(a_in_ready), 64'd0);
        chk("midrst_hold", 64'(a_core_hold), 64'd1);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        prog = '{32'h11111111, 32'h22222222, c_hlt_opcode};
        run_prog(prog, 0, 1);

        for (int t = 0; t < 8; t++) begin
            int len;
            len = int'($urandom_range(1, 12));
            prog.delete();
            for (int i = 0; i < len - 1; i++) prog.push_back($urandom);
            prog.push_back(c_hlt_opcode);
            run_prog(prog, 2, int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
